if_id_skid: RTL and testbench

- IF/ID pipeline boundary. Sits directly downstream of the IF stage.
- Captures the IF stage's PC+4 and fetched instruction, and presents them to the ID stage with a valid/ready handshake.
- A 2-entry skid buffer absorbs one-cycle ID back-pressure without losing a fetched word.
- Supports branch flush (bubble insertion) and a saturating stall-cycle counter for performance debug.

---
 rtl/if_id_skid.sv | 124 ++++++++++++
 tb/tb_if_id_skid.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid.sv
`default_nettype none
// ============================================================================
// if_id_skid : IF/ID boundary with 2-entry skid buffer, flush and stall counter
// Rev 1.0
// ============================================================================
module if_id_skid #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000000,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [DATA_W-1:0] if_pc4,
    input  logic [DATA_W-1:0] if_instr,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_pc4,
    output logic [DATA_W-1:0] id_instr,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_pc4;
    logic [DATA_W-1:0] main_instr;
    logic [DATA_W-1:0] skid_pc4;
    logic [DATA_W-1:0] skid_instr;
    logic              fire_in;
    logic              fire_out;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    // Ready depends only on registered state, so no id_ready -> if_ready path.
    assign if_ready  = (state != TWO) && reset_n;
    assign id_valid  = (state != EMPTY);
    assign id_pc4    = main_pc4;
    assign id_instr  = id_valid ? main_instr : NOP_INSTR;
    assign occupancy = state;
    assign fire_in   = if_valid && if_ready;
    assign fire_out  = id_valid && id_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (fire_in) begin
                    load_main_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (fire_in && fire_out) begin
                    load_main_in = 1'b1;
                end else if (fire_in) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end else if (fire_out) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (fire_out) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush drops every held and incoming word; data registers keep their values.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= EMPTY;
            main_pc4   <= '0;
            main_instr <= NOP_INSTR;
            skid_pc4   <= '0;
            skid_instr <= NOP_INSTR;
        end else begin
            state <= state_nxt;
            if (load_main_in) begin
                main_pc4   <= if_pc4;
                main_instr <= if_instr;
            end else if (load_main_skid) begin
                main_pc4   <= skid_pc4;
                main_instr <= skid_instr;
            end
            if (load_skid) begin
                skid_pc4   <= if_pc4;
                skid_instr <= if_instr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (if_valid && (state == TWO) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid.sv
`default_nettype none
// ============================================================================
// tb_if_id_skid : directed self-checking bench for if_id_skid
// Rev 1.0
// ============================================================================
module tb_if_id_skid;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        if_ready4;
    logic        id_valid4;
    logic [31:0] id_pc4_4;
    logic [31:0] id_instr4;
    logic [1:0]  occupancy4;
    logic [3:0]  stall_cnt4;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall;

    always #5 clk = ~clk;

    if_id_skid dut (
        .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_pc4(if_pc4), .if_instr(if_instr), .flush(flush), .id_valid(id_valid),
        .id_ready(id_ready), .id_pc4(id_pc4), .id_instr(id_instr),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    if_id_skid #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_ready(if_ready4),
        .if_pc4(if_pc4), .if_instr(if_instr), .flush(flush), .id_valid(id_valid4),
        .id_ready(id_ready), .id_pc4(id_pc4_4), .id_instr(id_instr4),
        .occupancy(occupancy4), .stall_cnt(stall_cnt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        if_valid = v;
        if_pc4   = pc;
        if_instr = ins;
        id_ready = rdy;
        flush    = fl;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid got %0h exp 0", id_valid); end
        n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_id_instr got %0h exp 0", id_instr); end
        n_checks++; if (id_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc4 got %0h exp 0", id_pc4); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready got %0h exp 0", if_ready); end
        reset_n = 1'b1;
        tick();
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL release_if_ready got %0h exp 1", if_ready); end
        exp_stall = 0;
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        pcs = '{32'd4, 32'd8, 32'd12};
        ins = '{32'hA1, 32'hA2, 32'hA3};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pcs[i], ins[i], 1'b1, 1'b0);
            tick();
            n_checks++; if (id_valid !== 1'b1 || id_pc4 !== pcs[i] || id_instr !== ins[i])
                begin n_fail++; $display("FAIL stream_word%0d got v=%0h pc=%0h ins=%0h exp v=1 pc=%0h ins=%0h", i, id_valid, id_pc4, id_instr, pcs[i], ins[i]); end
            n_checks++; if (occupancy !== 2'd1 || if_ready !== 1'b1)
                begin n_fail++; $display("FAIL stream_occ%0d got occ=%0d rdy=%0h exp occ=1 rdy=1", i, occupancy, if_ready); end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        n_checks++; if (id_valid !== 1'b0 || occupancy !== 2'd0)
            begin n_fail++; $display("FAIL stream_drain got v=%0h occ=%0d exp v=0 occ=0", id_valid, occupancy); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 32'd4, 32'hA1, 1'b0, 1'b0);
        tick();
        n_checks++; if (id_instr !== 32'hA1 || occupancy !== 2'd1)
            begin n_fail++; $display("FAIL bp_first got ins=%0h occ=%0d exp ins=a1 occ=1", id_instr, occupancy); end
        drive(1'b1, 32'd8, 32'hA2, 1'b0, 1'b0);
        tick();
        n_checks++; if (occupancy !== 2'd2 || if_ready !== 1'b0 || id_instr !== 32'hA1)
            begin n_fail++; $display("FAIL bp_full got occ=%0d rdy=%0h ins=%0h exp occ=2 rdy=0 ins=a1", occupancy, if_ready, id_instr); end
        drive(1'b1, 32'd12, 32'hA3, 1'b0, 1'b0);
        tick();
        exp_stall++;
        n_checks++; if (stall_cnt !== 16'(exp_stall) || id_pc4 !== 32'd4 || id_instr !== 32'hA1)
            begin n_fail++; $display("FAIL bp_stall1 got cnt=%0d pc=%0h ins=%0h exp cnt=%0d pc=4 ins=a1", stall_cnt, id_pc4, id_instr, exp_stall); end
        drive(1'b1, 32'd12, 32'hA3, 1'b1, 1'b0);
        tick();
        exp_stall++;
        n_checks++; if (stall_cnt !== 16'(exp_stall) || id_instr !== 32'hA2 || id_pc4 !== 32'd8 || occupancy !== 2'd1)
            begin n_fail++; $display("FAIL bp_second got cnt=%0d pc=%0h ins=%0h occ=%0d exp cnt=%0d pc=8 ins=a2 occ=1", stall_cnt, id_pc4, id_instr, occupancy, exp_stall); end
        tick();
        n_checks++; if (id_instr !== 32'hA3 || id_pc4 !== 32'd12 || occupancy !== 2'd1)
            begin n_fail++; $display("FAIL bp_third got pc=%0h ins=%0h occ=%0d exp pc=c ins=a3 occ=1", id_pc4, id_instr, occupancy); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        n_checks++; if (occupancy !== 2'd0 || stall_cnt !== 16'(exp_stall))
            begin n_fail++; $display("FAIL bp_drain got occ=%0d cnt=%0d exp occ=0 cnt=%0d", occupancy, stall_cnt, exp_stall); end
    endtask

    task automatic test_flush_two();
        drive(1'b1, 32'd4, 32'hA1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'd8, 32'hA2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'd12, 32'hA3, 1'b0, 1'b1);
        tick();
        exp_stall++;
        n_checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || occupancy !== 2'd0 || if_ready !== 1'b1)
            begin n_fail++; $display("FAIL flush2_clear got v=%0h ins=%0h occ=%0d rdy=%0h exp v=0 ins=0 occ=0 rdy=1", id_valid, id_instr, occupancy, if_ready); end
        n_checks++; if (stall_cnt !== 16'(exp_stall))
            begin n_fail++; $display("FAIL flush2_stall got %0d exp %0d", stall_cnt, exp_stall); end
        drive(1'b1, 32'h40, 32'hB1, 1'b1, 1'b0);
        tick();
        n_checks++; if (id_valid !== 1'b1 || id_pc4 !== 32'h40 || id_instr !== 32'hB1)
            begin n_fail++; $display("FAIL flush2_next got v=%0h pc=%0h ins=%0h exp v=1 pc=40 ins=b1", id_valid, id_pc4, id_instr); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        n_checks++; if (id_valid !== 1'b0 || occupancy !== 2'd0)
            begin n_fail++; $display("FAIL flush2_noold got v=%0h ins=%0h exp v=0", id_valid, id_instr); end
    endtask

    task automatic test_flush_one();
        drive(1'b1, 32'h50, 32'hC1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h54, 32'hC2, 1'b1, 1'b1);
        tick();
        n_checks++; if (id_valid !== 1'b0 || occupancy !== 2'd0 || id_instr !== 32'h0)
            begin n_fail++; $display("FAIL flush1_clear got v=%0h occ=%0d ins=%0h exp v=0 occ=0 ins=0", id_valid, occupancy, id_instr); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        n_checks++; if (id_valid !== 1'b0 || occupancy !== 2'd0)
            begin n_fail++; $display("FAIL flush1_nodup got v=%0h occ=%0d exp v=0 occ=0", id_valid, occupancy); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h60, 32'hD1, 1'b0, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (stall_cnt !== 16'(exp_stall + 5) || occupancy !== 2'd2)
            begin n_fail++; $display("FAIL rmid_pre got cnt=%0d occ=%0d exp cnt=%0d occ=2", stall_cnt, occupancy, exp_stall + 5); end
        reset_n = 1'b0;
        tick();
        n_checks++; if (occupancy !== 2'd0 || stall_cnt !== 16'd0 || id_instr !== 32'h0 || id_valid !== 1'b0)
            begin n_fail++; $display("FAIL rmid_clear got occ=%0d cnt=%0d ins=%0h v=%0h exp 0 0 0 0", occupancy, stall_cnt, id_instr, id_valid); end
        tick();
        n_checks++; if (if_ready !== 1'b0 || stall_cnt !== 16'd0)
            begin n_fail++; $display("FAIL rmid_hold got rdy=%0h cnt=%0d exp rdy=0 cnt=0", if_ready, stall_cnt); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick();
        n_checks++; if (if_ready !== 1'b1)
            begin n_fail++; $display("FAIL rmid_release got rdy=%0h exp 1", if_ready); end
        exp_stall = 0;
    endtask

    task automatic test_saturation();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        drive(1'b1, 32'h70, 32'hE1, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            // two edges fill the buffer, every later edge is a stall
            if (i == 16) begin
                n_checks++; if (stall_cnt4 !== 4'd14)
                    begin n_fail++; $display("FAIL sat_pre got %0d exp 14", stall_cnt4); end
            end
            if (i == 17 || i == 20) begin
                n_checks++; if (stall_cnt4 !== 4'd15)
                    begin n_fail++; $display("FAIL sat_hold%0d got %0d exp 15", i, stall_cnt4); end
            end
        end
        n_checks++; if (stall_cnt !== 16'd18)
            begin n_fail++; $display("FAIL sat_wide got %0d exp 18", stall_cnt); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_two();
        test_flush_one();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
